triangle_setup: RTL and testbench
=================================

// Module: triangle_setup
// PURPOSE
//  Consumer end of the geometry engine's screen-space vertex stream. Accepts vertices (Q16.16 x/y) over valid/ready
//  and assembles every 3 consecutive vertices into a triangle (list topology, no strips).
//  Per triangle: rounds to integer pixels, computes twice-signed area and clamped bounding box, and culls
//  degenerate/back-facing/off-screen triangles. Surviving triangles go to the rasterizer over valid/ready.
// PARAMETERS
//  SCREEN_W   320  screen width in pixels; x clamp range [0, SCREEN_W-1]
//  SCREEN_H   240  screen height in pixels; y clamp range [0, SCREEN_H-1]
//  CULL_BACK  1    1: cull area2<0 (back-facing); 0: keep both windings
// PORTS
//  i_clk         in   1   clock
//  i_rst         in   1   reset, asynchronous, active-high
//  i_vtx_valid   in   1   vertex valid
//  o_vtx_ready   out  1   vertex ready (high only in S_COLLECT)
//  i_vtx_x       in   32  vertex x, signed Q16.16 screen coords
//  i_vtx_y       in   32  vertex y, signed Q16.16 screen coords
//  o_tri_valid   out  1   triangle valid
//  i_tri_ready   in   1   rasterizer ready
//  o_x0,o_x1,o_x2 out 16  signed integer pixel x of vertices 0..2 (arrival order)
//  o_y0,o_y1,o_y2 out 16  signed integer pixel y of vertices 0..2
//  o_area2       out  36  signed twice-area, pixel^2
//  o_bb_xmin,o_bb_xmax out 16  bbox x, clamped, unsigned
//  o_bb_ymin,o_bb_ymax out 16  bbox y, clamped, unsigned
//  o_tri_count   out  16  triangles emitted, wraps 0xFFFF->0
//  o_cull_count  out  16  triangles culled, wraps 0xFFFF->0
// BEHAVIOUR
//  - Reset (async, i_rst=1): state=S_COLLECT, vertex index=0, all outputs 0 except o_vtx_ready=1.
//  - Vertex handshake: i_vtx_valid & o_vtx_ready on a rising edge. Rounding: p = (v + 32'h8000) >>> 16, keep low 16 bits.
//  - FSM:
//    S_COLLECT: store rounded vertex at index idx, idx++. Handshake with idx==2 -> idx=0, go S_AREA.
//    S_AREA (1 cycle): area2 = (x1-x0)*(y2-y0) - (x2-x0)*(y1-y0).
//      17-bit signed diffs, 34-bit products, 36-bit signed sum; no overflow possible. Go S_BBOX.
//    S_BBOX (1 cycle): raw min/max over the 3 vertices.
//      cull = (area2==0) | (CULL_BACK & area2<0) | raw xmax<0 | raw xmin>SCREEN_W-1 | raw ymax<0 | raw ymin>SCREEN_H-1.
//      Clamp bbox to screen. cull -> o_cull_count++, go S_COLLECT; else go S_OUTPUT.
//    S_OUTPUT: o_tri_valid=1; all o_x*/o_y*/o_area2/o_bb_* stable while valid.
//      i_tri_ready=1 at an edge -> o_tri_count++, go S_COLLECT. Valid is never withdrawn without ready.
//  - Latency: 3rd-vertex handshake at edge T -> o_tri_valid=1 after edge T+2 (i.e. visible in cycle after T+2). Culled: o_vtx_ready=1 again after T+2.
//  - Throughput: max 1 triangle per 6 cycles. o_vtx_ready=0 in S_AREA/S_BBOX/S_OUTPUT; no vertex is dropped.
//  - i_tri_ready is ignored outside S_OUTPUT.
//  - Outputs hold the last triangle's values after acceptance until the next one is loaded.
//  - Reset mid-operation: partial triangle discarded, idx=0; counters cleared; next 3 vertices form a new triangle.
//  - Counters wrap silently. o_tri_count and o_cull_count never increment in the same cycle.
// TESTING
//  1. Front-facing: (10,10),(50,10),(10,40), x/y e.g. 32'h000A0000.
//     -> o_area2=1200; bbox 10..50 / 10..40; o_tri_valid 3 cycles after 3rd handshake; o_tri_count=1.
//  2. Reversed winding (10,10),(10,40),(50,10), CULL_BACK=1.
//     -> o_area2=-1200, culled, no o_tri_valid, o_cull_count=1. With CULL_BACK=0: emitted.
//  3. Degenerate collinear (0,0),(5,5),(10,10) -> area2=0, culled.
//     Rounding: x=32'h00148000 (20.5) -> pixel 21.
//  4. Clamp/off-screen: (-20,10),(50,10),(10,40) -> emitted, bbox_xmin=0.
//     All x in {400,410,420} with W=320 -> culled.
//  5. Backpressure: i_tri_ready=0 for 5 cycles in S_OUTPUT
//     -> o_tri_valid and all outputs stable, o_vtx_ready=0; accepted on 6th cycle, then o_vtx_ready=1.
//  6. Reset after 2 vertices, then 3 new vertices -> exactly one triangle made of the 3 new vertices; counters restart at 0.

Source files
------------

// File: rtl/triangle_setup.sv
// triangle_setup
//   Receives screen-space vertices (signed Q16.16 x/y) over a valid/ready
//   handshake and groups every three consecutive vertices into one triangle.
//   For each triangle it rounds the vertices to integer pixels, computes the
//   signed twice-area and a bounding box clamped to the screen, and drops
//   triangles that are degenerate, back-facing (optional) or fully off-screen.
//   Triangles that survive are offered to the rasterizer over valid/ready.
//
// Ports
//   i_clk, i_rst                 clock, asynchronous active-high reset
//   i_vtx_valid/o_vtx_ready      vertex handshake (ready only while collecting)
//   i_vtx_x, i_vtx_y             vertex coordinates, signed Q16.16
//   o_tri_valid/i_tri_ready      triangle handshake towards the rasterizer
//   o_x0..o_x2, o_y0..o_y2       rounded pixel coordinates, arrival order
//   o_area2                      signed twice-area in pixel^2
//   o_bb_xmin..o_bb_ymax         bounding box clamped to the screen
//   o_tri_count, o_cull_count    wrapping counts of emitted / culled triangles
module triangle_setup #(
   parameter int unsigned SCREEN_W  = 320,
   parameter int unsigned SCREEN_H  = 240,
   parameter bit          CULL_BACK = 1'b1
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_vtx_valid,
   output logic               o_vtx_ready,
   input  logic [31:0]        i_vtx_x,
   input  logic [31:0]        i_vtx_y,
   output logic               o_tri_valid,
   input  logic               i_tri_ready,
   output logic signed [15:0] o_x0,
   output logic signed [15:0] o_x1,
   output logic signed [15:0] o_x2,
   output logic signed [15:0] o_y0,
   output logic signed [15:0] o_y1,
   output logic signed [15:0] o_y2,
   output logic signed [35:0] o_area2,
   output logic [15:0]        o_bb_xmin,
   output logic [15:0]        o_bb_xmax,
   output logic [15:0]        o_bb_ymin,
   output logic [15:0]        o_bb_ymax,
   output logic [15:0]        o_tri_count,
   output logic [15:0]        o_cull_count
);

   localparam logic signed [15:0] X_LIM = 16'(SCREEN_W - 1);
   localparam logic signed [15:0] Y_LIM = 16'(SCREEN_H - 1);

   typedef enum logic [1:0] {
      S_COLLECT,
      S_AREA,
      S_BBOX,
      S_OUTPUT
   } state_t;

   state_t state, state_nx;

   logic [1:0]         idx;
   logic signed [15:0] vx [3];
   logic signed [15:0] vy [3];
   logic signed [35:0] area_r;

   // Adding 0x8000 then shifting right by 16 equals the integer part plus
   // the half bit as a carry, so only bits 31:15 of each coordinate matter.
   logic signed [15:0] rx, ry;
   logic               unused_frac;
   assign rx          = i_vtx_x[31:16] + {15'd0, i_vtx_x[15]};
   assign ry          = i_vtx_y[31:16] + {15'd0, i_vtx_y[15]};
   assign unused_frac = ^{i_vtx_x[14:0], i_vtx_y[14:0]};

   logic vtx_hs;
   assign vtx_hs = i_vtx_valid && (state == S_COLLECT);

   // Twice-area from the stored vertices; 17-bit differences cannot overflow.
   logic signed [16:0] dx1, dy1, dx2, dy2;
   logic signed [33:0] p0, p1;
   logic signed [35:0] area_c;
   assign dx1    = {vx[1][15], vx[1]} - {vx[0][15], vx[0]};
   assign dy1    = {vy[1][15], vy[1]} - {vy[0][15], vy[0]};
   assign dx2    = {vx[2][15], vx[2]} - {vx[0][15], vx[0]};
   assign dy2    = {vy[2][15], vy[2]} - {vy[0][15], vy[0]};
   assign p0     = dx1 * dy2;
   assign p1     = dx2 * dy1;
   assign area_c = {{2{p0[33]}}, p0} - {{2{p1[33]}}, p1};

   // Raw (unclamped) bounding box
   logic signed [15:0] xmin, xmax, ymin, ymax;
   always_comb begin
      xmin = vx[0];
      xmax = vx[0];
      ymin = vy[0];
      ymax = vy[0];
      for (int unsigned i = 1; i < 3; i++) begin
         if (vx[i] < xmin) xmin = vx[i];
         if (vx[i] > xmax) xmax = vx[i];
         if (vy[i] < ymin) ymin = vy[i];
         if (vy[i] > ymax) ymax = vy[i];
      end
   end

   function automatic logic [15:0] clamp(input logic signed [15:0] v,
                                         input logic signed [15:0] lim);
      if (v < 0)
         return '0;
      else if (v > lim)
         return lim;
      else
         return v;
   endfunction

   logic cull;
   assign cull = (area_r == 0) || (CULL_BACK && (area_r < 0)) ||
                 (xmax < 0) || (xmin > X_LIM) ||
                 (ymax < 0) || (ymin > Y_LIM);

   // Next state and handshake outputs
   always_comb begin
      state_nx    = state;
      o_vtx_ready = 1'b0;
      o_tri_valid = 1'b0;
      case (state)
         S_COLLECT: begin
            o_vtx_ready = 1'b1;
            if (i_vtx_valid && idx == 2'd2) state_nx = S_AREA;
         end
         S_AREA:   state_nx = S_BBOX;
         S_BBOX:   state_nx = cull ? S_COLLECT : S_OUTPUT;
         S_OUTPUT: begin
            o_tri_valid = 1'b1;
            if (i_tri_ready) state_nx = S_COLLECT;
         end
         default:  state_nx = S_COLLECT;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state        <= S_COLLECT;
         idx          <= '0;
         area_r       <= '0;
         for (int unsigned i = 0; i < 3; i++) begin
            vx[i] <= '0;
            vy[i] <= '0;
         end
         o_x0         <= '0;
         o_x1         <= '0;
         o_x2         <= '0;
         o_y0         <= '0;
         o_y1         <= '0;
         o_y2         <= '0;
         o_area2      <= '0;
         o_bb_xmin    <= '0;
         o_bb_xmax    <= '0;
         o_bb_ymin    <= '0;
         o_bb_ymax    <= '0;
         o_tri_count  <= '0;
         o_cull_count <= '0;
      end else begin
         state <= state_nx;
         if (vtx_hs) begin
            vx[idx] <= rx;
            vy[idx] <= ry;
            idx     <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
         end
         if (state == S_AREA) area_r <= area_c;
         // The published triangle only changes when a surviving triangle
         // is loaded, so outputs hold through collection of the next one.
         if (state == S_BBOX) begin
            if (cull) begin
               o_cull_count <= o_cull_count + 16'd1;
            end else begin
               o_x0      <= vx[0];
               o_x1      <= vx[1];
               o_x2      <= vx[2];
               o_y0      <= vy[0];
               o_y1      <= vy[1];
               o_y2      <= vy[2];
               o_area2   <= area_r;
               o_bb_xmin <= clamp(xmin, X_LIM);
               o_bb_xmax <= clamp(xmax, X_LIM);
               o_bb_ymin <= clamp(ymin, Y_LIM);
               o_bb_ymax <= clamp(ymax, Y_LIM);
            end
         end
         if (state == S_OUTPUT && i_tri_ready) o_tri_count <= o_tri_count + 16'd1;
      end
   end

endmodule

// File: tb/tb_triangle_setup.sv
// tb_triangle_setup
//   Directed bench for triangle_setup. Instance "a" uses default parameters
//   (back-face culling on); instance "b" shares the vertex stream with
//   culling of back faces disabled and always accepts its triangles.
module tb_triangle_setup;

   logic        clk = 1'b0;
   logic        rst;
   logic        vtx_valid;
   logic [31:0] vtx_x, vtx_y;
   logic        tri_ready;

   logic               a_vtx_ready, a_tri_valid;
   logic signed [15:0] a_x0, a_x1, a_x2, a_y0, a_y1, a_y2;
   logic signed [35:0] a_area2;
   logic [15:0]        a_bb_xmin, a_bb_xmax, a_bb_ymin, a_bb_ymax;
   logic [15:0]        a_tri_count, a_cull_count;

   logic               b_vtx_ready, b_tri_valid;
   logic signed [15:0] b_x0, b_x1, b_x2, b_y0, b_y1, b_y2;
   logic signed [35:0] b_area2;
   logic [15:0]        b_bb_xmin, b_bb_xmax, b_bb_ymin, b_bb_ymax;
   logic [15:0]        b_tri_count, b_cull_count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   triangle_setup dut_a (
      .i_clk(clk), .i_rst(rst),
      .i_vtx_valid(vtx_valid), .o_vtx_ready(a_vtx_ready),
      .i_vtx_x(vtx_x), .i_vtx_y(vtx_y),
      .o_tri_valid(a_tri_valid), .i_tri_ready(tri_ready),
      .o_x0(a_x0), .o_x1(a_x1), .o_x2(a_x2),
      .o_y0(a_y0), .o_y1(a_y1), .o_y2(a_y2),
      .o_area2(a_area2),
      .o_bb_xmin(a_bb_xmin), .o_bb_xmax(a_bb_xmax),
      .o_bb_ymin(a_bb_ymin), .o_bb_ymax(a_bb_ymax),
      .o_tri_count(a_tri_count), .o_cull_count(a_cull_count)
   );

   triangle_setup #(.CULL_BACK(1'b0)) dut_b (
      .i_clk(clk), .i_rst(rst),
      .i_vtx_valid(vtx_valid), .o_vtx_ready(b_vtx_ready),
      .i_vtx_x(vtx_x), .i_vtx_y(vtx_y),
      .o_tri_valid(b_tri_valid), .i_tri_ready(1'b1),
      .o_x0(b_x0), .o_x1(b_x1), .o_x2(b_x2),
      .o_y0(b_y0), .o_y1(b_y1), .o_y2(b_y2),
      .o_area2(b_area2),
      .o_bb_xmin(b_bb_xmin), .o_bb_xmax(b_bb_xmax),
      .o_bb_ymin(b_bb_ymin), .o_bb_ymax(b_bb_ymax),
      .o_tri_count(b_tri_count), .o_cull_count(b_cull_count)
   );

   task automatic check(input string tag, input longint got, input longint exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] px(input int p);
      return 32'(p) << 16;
   endfunction

   // Present one vertex for exactly one edge, once both instances are ready.
   task automatic send_vtx(input logic [31:0] x, input logic [31:0] y);
      int n = 0;
      @(negedge clk);
      while (!(a_vtx_ready && b_vtx_ready) && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("vtx_ready_wait", longint'(n < 50), 1);
      vtx_x     = x;
      vtx_y     = y;
      vtx_valid = 1'b1;
      @(posedge clk);
      #1 vtx_valid = 1'b0;
   endtask

   task automatic send_tri(input int x0, input int y0, input int x1,
                           input int y1, input int x2, input int y2);
      send_vtx(px(x0), px(y0));
      send_vtx(px(x1), px(y1));
      send_vtx(px(x2), px(y2));
   endtask

   // Observe the three cycles following the third handshake.
   task automatic wait_result(input string tag, input logic exp_valid);
      @(negedge clk) check({tag, "_lat1"}, a_tri_valid, 0);
      @(negedge clk) check({tag, "_lat2"}, a_tri_valid, 0);
      @(negedge clk) check({tag, "_lat3"}, a_tri_valid, exp_valid);
   endtask

   task automatic accept_tri();
      tri_ready = 1'b1;
      @(posedge clk);
      #1 tri_ready = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      rst       = 1'b1;
      vtx_valid = 1'b0;
      vtx_x     = '0;
      vtx_y     = '0;
      tri_ready = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_vtx_ready", a_vtx_ready, 1);
      check("rst_tri_valid", a_tri_valid, 0);
      check("rst_area2", $signed(a_area2), 0);
      check("rst_tri_count", a_tri_count, 0);
      check("rst_cull_count", a_cull_count, 0);
      rst = 1'b0;

      // Front-facing triangle
      send_tri(10, 10, 50, 10, 10, 40);
      wait_result("t1", 1'b1);
      check("t1_area2", $signed(a_area2), 1200);
      check("t1_x1", $signed(a_x1), 50);
      check("t1_y2", $signed(a_y2), 40);
      check("t1_bb_xmin", a_bb_xmin, 10);
      check("t1_bb_xmax", a_bb_xmax, 50);
      check("t1_bb_ymin", a_bb_ymin, 10);
      check("t1_bb_ymax", a_bb_ymax, 40);
      check("t1_vtx_ready", a_vtx_ready, 0);
      accept_tri();
      check("t1_tri_count", a_tri_count, 1);
      check("t1_vtx_ready_after", a_vtx_ready, 1);

      // Reversed winding: culled by a, emitted by b
      send_tri(10, 10, 10, 40, 50, 10);
      wait_result("t2", 1'b0);
      check("t2_cull_count", a_cull_count, 1);
      check("t2_vtx_ready", a_vtx_ready, 1);
      check("t2_area2_held", $signed(a_area2), 1200);
      check("t2_b_valid", b_tri_valid, 1);
      check("t2_b_area2", $signed(b_area2), -1200);
      @(negedge clk);
      check("t2_b_tri_count", b_tri_count, 2);

      // Degenerate collinear
      send_tri(0, 0, 5, 5, 10, 10);
      wait_result("t3", 1'b0);
      check("t3_cull_count", a_cull_count, 2);
      check("t3_b_cull_count", b_cull_count, 1);

      // Partly left of screen: emitted with clamped bbox
      send_tri(-20, 10, 50, 10, 10, 40);
      wait_result("t4", 1'b1);
      check("t4_area2", $signed(a_area2), 2100);
      check("t4_x0", $signed(a_x0), -20);
      check("t4_bb_xmin", a_bb_xmin, 0);
      check("t4_bb_xmax", a_bb_xmax, 50);
      accept_tri();
      check("t4_tri_count", a_tri_count, 2);

      // Entirely right of screen
      send_tri(400, 10, 410, 10, 420, 40);
      wait_result("t4off", 1'b0);
      check("t4off_cull_count", a_cull_count, 3);
      check("t4off_b_cull_count", b_cull_count, 2);

      // Rounding 20.5 -> 21, then backpressure for five cycles
      send_vtx(32'h0014_8000, px(10));
      send_vtx(px(50), px(10));
      send_vtx(px(10), px(40));
      wait_result("t5", 1'b1);
      check("t5_x0_round", $signed(a_x0), 21);
      check("t5_bb_xmin", a_bb_xmin, 10);
      for (int i = 0; i < 5; i++) begin
         check("t5_bp_valid", a_tri_valid, 1);
         check("t5_bp_area2", $signed(a_area2), 870);
         check("t5_bp_x0", $signed(a_x0), 21);
         check("t5_bp_vtx_ready", a_vtx_ready, 0);
         @(negedge clk);
      end
      accept_tri();
      check("t5_tri_count", a_tri_count, 3);
      check("t5_vtx_ready_after", a_vtx_ready, 1);
      check("t5_area2_held", $signed(a_area2), 870);

      // Reset after a partial triangle
      send_vtx(px(1), px(1));
      send_vtx(px(2), px(2));
      @(negedge clk) rst = 1'b1;
      @(negedge clk);
      check("t6_rst_tri_count", a_tri_count, 0);
      check("t6_rst_cull_count", a_cull_count, 0);
      check("t6_rst_area2", $signed(a_area2), 0);
      rst = 1'b0;
      send_tri(10, 10, 50, 10, 10, 40);
      wait_result("t6", 1'b1);
      check("t6_x0", $signed(a_x0), 10);
      check("t6_y0", $signed(a_y0), 10);
      check("t6_x1", $signed(a_x1), 50);
      check("t6_area2", $signed(a_area2), 1200);
      accept_tri();
      check("t6_tri_count", a_tri_count, 1);
      check("t6_cull_count", a_cull_count, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
